blck_encoder: RTL

BLCK_ENCODER -- requirements
Module: blck_encoder

---
 rtl/blck_encoder_pkg.sv | 17 +
 rtl/blck_encoder.sv | 88 ++++++++
 2 files changed

// File: rtl/blck_encoder_pkg.sv
// Shared sizing defaults, word-count helper and FSM encoding for the block encoder.
package blck_encoder_pkg;

   localparam int BUS_SIZE_DEF = 32;
   localparam int N_DEF        = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BLCK = 2'd1,
      TAG  = 2'd2
   } state_t;

   function automatic int words_of(input int bus_size, input int blk_size);
      return blk_size / bus_size;
   endfunction

endpackage

// File: rtl/blck_encoder.sv
// Serialises a captured n-bit block or tag onto a BUS_SIZE-bit stream, lowest word
// first, stopping at the first word whose byte-validity field is empty.
module blck_encoder
   import blck_encoder_pkg::*;
#(
   parameter int BUS_SIZE = BUS_SIZE_DEF,
   parameter int n        = N_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [n-1:0]          in_blck,
   input  logic [n/8-1:0]        in_blck_validity,
   input  logic [n-1:0]          in_tag,
   input  logic                  in_sel_tag,
   input  logic                  in_last,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [BUS_SIZE-1:0]   out_data,
   output logic [BUS_SIZE/8-1:0] out_validity,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int NW = words_of(BUS_SIZE, n);
   localparam int BV = BUS_SIZE / 8;
   localparam int NX = (NW > 1) ? 1 : 0;

   state_t                      state;
   logic [NW-1:0][BUS_SIZE-1:0] data_reg;
   logic [NW-1:0][BV-1:0]       vld_reg;
   logic                        last_reg;

   logic [n/8-1:0] load_vld;
   logic           final_word;
   logic           word_acc;
   logic           load;

   // The current word is the last one when nothing valid follows it.
   assign final_word = (NW == 1) || (vld_reg[NX] == '0);
   assign out_valid  = (state != IDLE) && (vld_reg[0] != '0);
   assign word_acc   = out_valid && out_ready;
   assign in_ready   = (state == IDLE) || (word_acc && final_word);
   assign load       = in_valid && in_ready;
   assign load_vld   = in_sel_tag ? '1 : in_blck_validity;

   always_comb begin
      out_data = '0;
      for (int b = 0; b < BV; b++)
         if (out_valid && vld_reg[0][b]) out_data[8*b +: 8] = data_reg[0][8*b +: 8];
   end

   assign out_validity = out_valid ? vld_reg[0] : '0;
   assign out_last     = out_valid && final_word && last_reg;

   // A load takes priority so a new item can replace one finishing this cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         data_reg <= '0;
         vld_reg  <= '0;
         last_reg <= 1'b0;
      end else if (load) begin
         if (load_vld[BV-1:0] != '0) begin
            state    <= in_sel_tag ? TAG : BLCK;
            data_reg <= in_sel_tag ? in_tag : in_blck;
            vld_reg  <= load_vld;
            last_reg <= in_last;
         end else begin
            state    <= IDLE;
            data_reg <= '0;
            vld_reg  <= '0;
            last_reg <= 1'b0;
         end
      end else if (word_acc) begin
         if (final_word) begin
            state    <= IDLE;
            data_reg <= '0;
            vld_reg  <= '0;
            last_reg <= 1'b0;
         end else begin
            data_reg <= data_reg >> BUS_SIZE;
            vld_reg  <= vld_reg >> BV;
         end
      end
   end

endmodule
